// File: rtl/activation_pipe.sv
// activation_pipe
//   Three-stage activation unit for a row of accumulator lanes.
//     S1: capture the accepted beat (lanes plus func/is_signed/shift)
//     S2: rounding right shift of every lane
//     S3: activation function and saturation into the output register
//   All stages advance together on a single global enable, so bubbles stay
//   in place and a stalled output freezes the whole pipe.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   in_valid     input beat valid
//   in_ready     beat accepted this cycle when in_valid is also high
//   data_in      MATRIX_WIDTH lanes of IN_WIDTH bits, lane i at [i*IN_WIDTH +: IN_WIDTH]
//   func         00 none, 01 relu, 10 leaky_relu, 11 hard_sigmoid
//   is_signed    lanes are two's complement when 1
//   shift        rounding right-shift amount, 0..IN_WIDTH-1
//   out_valid    output beat valid
//   out_ready    downstream accepts the output beat
//   data_out     MATRIX_WIDTH lanes of OUT_WIDTH bits, lane i at [i*OUT_WIDTH +: OUT_WIDTH]
//   out_sat      per-lane flag: result was clipped to the output range
//   sat_count    number of delivered beats with any out_sat bit set (saturating)
module activation_pipe #(
  parameter int MATRIX_WIDTH = 14,
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT_WIDTH  = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MATRIX_WIDTH*IN_WIDTH-1:0]  data_in,
  input  logic [1:0]                        func,
  input  logic                              is_signed,
  input  logic [SHIFT_WIDTH-1:0]            shift,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MATRIX_WIDTH*OUT_WIDTH-1:0] data_out,
  output logic [MATRIX_WIDTH-1:0]           out_sat,
  output logic [15:0]                       sat_count
);

  // Rounded value: one extra bit so the round-up carry never overflows.
  localparam int RW = IN_WIDTH + 1;
  // Activation work width: headroom for the sigmoid offset add.
  localparam int AW = IN_WIDTH + 3;

  localparam logic signed [AW-1:0] ONE    = AW'(1);
  localparam logic signed [AW-1:0] S_HI   = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [AW-1:0] S_LO   = -(ONE <<< (OUT_WIDTH - 1));
  localparam logic signed [AW-1:0] U_HI   = (ONE <<< OUT_WIDTH) - ONE;
  localparam logic signed [AW-1:0] HS_OFF = ONE <<< (OUT_WIDTH - 2);
  localparam logic signed [AW-1:0] HU_OFF = ONE <<< (OUT_WIDTH - 1);

  // Round-half-up right shift. Unsigned lanes are zero-extended, so the
  // arithmetic shift behaves as a logical one for them.
  function automatic logic signed [RW-1:0] round_lane(
    input logic [IN_WIDTH-1:0]    x,
    input logic                   sgn,
    input logic [SHIFT_WIDTH-1:0] sh
  );
    logic signed [RW-1:0] xe;
    logic signed [RW-1:0] q;
    logic signed [RW-1:0] half;
    logic                 rbit;
    xe   = sgn ? $signed({x[IN_WIDTH-1], x}) : $signed({1'b0, x});
    q    = xe >>> sh;
    half = $signed(RW'(1)) <<< (sh - 1'b1);
    rbit = (xe & half) != '0;
    if (sh == '0) begin
      return xe;
    end
    return q + $signed({{(RW-1){1'b0}}, rbit});
  endfunction

  // Returns {sat, y}. Relu zeroing of a negative signed lane is not a clip.
  function automatic logic [OUT_WIDTH:0] activate(
    input logic signed [RW-1:0] r,
    input logic [1:0]           fn,
    input logic                 sgn
  );
    logic signed [AW-1:0] v;
    logic signed [AW-1:0] lo;
    logic signed [AW-1:0] hi;
    logic                 zero;
    logic [OUT_WIDTH:0]   res;
    v    = {{(AW-RW){r[RW-1]}}, r};
    lo   = sgn ? S_LO : '0;
    hi   = sgn ? S_HI : U_HI;
    zero = 1'b0;
    case (fn)
      2'b01: zero = sgn && v[AW-1];
      2'b10: begin
        if (sgn && v[AW-1]) begin
          v = v >>> 3;
        end
      end
      2'b11: begin
        if (sgn) begin
          v  = (v >>> 2) + HS_OFF;
          lo = '0;
          hi = S_HI;
        end else begin
          v = (v >>> 1) + HU_OFF;
        end
      end
      default: ;
    endcase
    if (zero) begin
      res = '0;
    end else if (v > hi) begin
      res = {1'b1, OUT_WIDTH'(hi)};
    end else if (v < lo) begin
      res = {1'b1, OUT_WIDTH'(lo)};
    end else begin
      res = {1'b0, OUT_WIDTH'(v)};
    end
    return res;
  endfunction

  logic advance;

  // S1 registers
  logic                             s1_valid;
  logic [MATRIX_WIDTH*IN_WIDTH-1:0] s1_data;
  logic [1:0]                       s1_func;
  logic                             s1_signed;
  logic [SHIFT_WIDTH-1:0]           s1_shift;

  // S2 registers
  logic                 s2_valid;
  logic signed [RW-1:0] s2_r [MATRIX_WIDTH];
  logic [1:0]           s2_func;
  logic                 s2_signed;

  logic signed [RW-1:0]              r_next [MATRIX_WIDTH];
  logic [MATRIX_WIDTH*OUT_WIDTH-1:0] act_data;
  logic [MATRIX_WIDTH-1:0]           act_sat;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  always_comb begin
    for (int unsigned i = 0; i < MATRIX_WIDTH; i++) begin
      r_next[i] = round_lane(s1_data[i*IN_WIDTH +: IN_WIDTH], s1_signed, s1_shift);
    end
  end

  always_comb begin
    act_data = '0;
    act_sat  = '0;
    for (int unsigned i = 0; i < MATRIX_WIDTH; i++) begin
      {act_sat[i], act_data[i*OUT_WIDTH +: OUT_WIDTH]} = activate(s2_r[i], s2_func, s2_signed);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_func   <= '0;
      s1_signed <= 1'b0;
      s1_shift  <= '0;
      s2_valid  <= 1'b0;
      s2_func   <= '0;
      s2_signed <= 1'b0;
      for (int unsigned i = 0; i < MATRIX_WIDTH; i++) begin
        s2_r[i] <= '0;
      end
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= '0;
      sat_count <= '0;
    end else begin
      if (out_valid && out_ready && (|out_sat) && (sat_count != '1)) begin
        sat_count <= sat_count + 16'd1;
      end
      if (advance) begin
        s1_valid  <= in_valid;
        s1_data   <= data_in;
        s1_func   <= func;
        s1_signed <= is_signed;
        s1_shift  <= shift;
        s2_valid  <= s1_valid;
        s2_func   <= s1_func;
        s2_signed <= s1_signed;
        for (int unsigned i = 0; i < MATRIX_WIDTH; i++) begin
          s2_r[i] <= r_next[i];
        end
        out_valid <= s2_valid;
        data_out  <= act_data;
        // Bubbles never carry saturation flags.
        out_sat   <= s2_valid ? act_sat : '0;
      end
    end
  end

endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 14, lane count.
REQ-002 SHALL have parameter IN_WIDTH, default 32, signed/unsigned accumulator width per lane.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, output width per lane.
REQ-004 SHALL have parameter SHIFT_WIDTH, default 5, width of rounding shift field.
REQ-005 clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 data_in  input  MATRIX_WIDTH x IN_WIDTH  accumulator lanes.
REQ-010 func  input  2  00 none, 01 relu, 10 leaky_relu, 11 hard_sigmoid; sampled with beat.
REQ-011 is_signed  input  1  lanes two's complement when 1; sampled with beat.
REQ-012 shift  input  SHIFT_WIDTH  right-shift amount for rounding, 0..IN_WIDTH-1; sampled with beat.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 data_out  output  MATRIX_WIDTH x OUT_WIDTH  activated lanes.
REQ-016 out_sat  output  MATRIX_WIDTH  per-lane flag: value was clipped.
REQ-017 sat_count  output  16  beats delivered with any out_sat bit set.

Function
REQ-018 SHALL be a 3-stage pipeline: S1 capture, S2 round, S3 activate/saturate; func, is_signed, shift travel with their beat.
REQ-019 advance = !out_valid || out_ready; all stages SHALL move together only when advance=1 (global stall, bubbles not collapsed).
REQ-020 in_ready SHALL equal advance && !rst; beat accepted when in_valid && in_ready.
REQ-021 Latency SHALL be 3 cycles accept-to-out_valid with out_ready held 1; throughput 1 beat/cycle.
REQ-022 While out_valid && !out_ready, data_out, out_sat, out_valid SHALL hold stable; no beat lost, duplicated or reordered.
REQ-023 S2: shift=0 -> r=x; else r=(x>>shift)+x[shift-1], arithmetic shift when signed, logical otherwise; r width IN_WIDTH+1, no overflow.
REQ-024 Clamp range: signed [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; unsigned [0, 2^OUT_WIDTH-1].
REQ-025 none: y=clamp(r).
REQ-026 relu: signed r<0 -> 0 (not flagged), else clamp(r); unsigned same as none.
REQ-027 leaky_relu: signed r<0 -> clamp(r>>>3) (floor), else clamp(r); unsigned same as none.
REQ-028 hard_sigmoid: signed y=clamp((r>>>2)+2^(OUT_WIDTH-2)) into [0, 2^(OUT_WIDTH-1)-1]; unsigned y=clamp((r>>1)+2^(OUT_WIDTH-1)).
REQ-029 out_sat[i] SHALL be 1 iff lane i result was changed by clamping (relu zeroing excluded).
REQ-030 sat_count SHALL increment on out_valid && out_ready && |out_sat, saturating at 0xFFFF.

Reset
REQ-031 On rst: all stage valids 0, out_valid 0, data_out 0, out_sat 0, sat_count 0, in_ready 0.
REQ-032 rst mid-stream SHALL discard all in-flight beats; first cycle after rst low in_ready=1.

Verification
REQ-033 Reset: assert rst 2 cycles -> out_valid=0, data_out=0, sat_count=0; next cycle in_ready=1.
REQ-034 Signed relu, shift=8, out_ready=1: lanes 384, -256, 0x7FFF0000 -> 3 cycles later 2, 0, 127; out_sat=0b100.
REQ-035 Signed leaky_relu shift=0: lane -20 -> 0xFD (-3); lane -2000 -> 0x80, out_sat set; sat_count 1 after handshake.
REQ-036 Unsigned hard_sigmoid shift=0: lanes 100, 300 -> 178, 255; out_sat=0b10.
REQ-037 Backpressure: stream 6 beats, out_ready=0 cycles 2-6 -> in_ready=0 while stalled, data_out stable, all 6 delivered in order.
REQ-038 rst during 3 beats in flight -> out_valid stays 0 after rst, no stale beat emitted, sat_count=0.
